dmem_arbiter: RTL

Two-requester arbiter and sequencer for the byte-addressed data memory. Port 0 is the core load/store unit and port 1 is the program loader/debug port. The block latches one request, checks alignment, range and access type, and drives the memory's address/datawr/dmwr/dmctrl for exactly one access cycle. It then returns a registered completion to the winning port. It sits between the pipeline/loader and data_memory.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_arbiter_if.sv | 32 +++
 rtl/dmem_fault_chk.sv | 33 +++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: dmctrl encodings, FSM states,
// and the access-size helper also used by the core's exception logic.
package dmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] DM_BYTE  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_WORD  = 3'b010;
  localparam logic [2:0] DM_UBYTE = 3'b100;
  localparam logic [2:0] DM_UHALF = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Bytes touched by one access; illegal encodings report 1.
  function automatic logic [2:0] access_size(input logic [2:0] ctrl);
    case (ctrl)
      DM_HALF, DM_UHALF: access_size = 3'd2;
      DM_WORD:           access_size = 3'd4;
      default:           access_size = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signals of the arbiter, bundled for port lists.
interface dmem_arbiter_if;
  import dmem_pkg::*;

  logic [1:0]        req;
  logic [1:0]        we;
  logic [2:0]        ctrl0;
  logic [2:0]        ctrl1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        done;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datawr;
  logic              mem_dmwr;
  logic [2:0]        mem_dmctrl;
  logic [DATA_W-1:0] mem_datard;

  modport slave (
    input  req, we, ctrl0, ctrl1, addr0, addr1, wdata0, wdata1, mem_datard,
    output done, rdata, err, mem_address, mem_datawr, mem_dmwr, mem_dmctrl
  );

  modport master (
    output req, we, ctrl0, ctrl1, addr0, addr1, wdata0, wdata1, mem_datard,
    input  done, rdata, err, mem_address, mem_datawr, mem_dmwr, mem_dmctrl
  );

endinterface

// File: rtl/dmem_fault_chk.sv
// Combinational access check: illegal type, misalignment, or any byte past the
// end of data memory.
module dmem_fault_chk
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic [2:0]        ctrl,
  input  logic [ADDR_W-1:0] addr,
  output logic              fault
);

  localparam int unsigned SUM_W = ADDR_W + 1;

  logic             illegal;
  logic             misalign;
  logic [SUM_W-1:0] last_byte;

  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    case (ctrl)
      DM_BYTE, DM_UBYTE: misalign = 1'b0;
      DM_HALF, DM_UHALF: misalign = addr[0];
      DM_WORD:           misalign = (addr[1:0] != 2'b00);
      default:           illegal  = 1'b1;
    endcase
    // Extra bit keeps addresses near 2^32 from wrapping below MEM_BYTES.
    last_byte = {1'b0, addr} + SUM_W'(access_size(ctrl)) - SUM_W'(1);
    fault     = illegal | misalign | (last_byte >= SUM_W'(MEM_BYTES));
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter that sequences one checked data-memory access
// per grant and returns a registered completion to the winning port.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_datawr_q, mem_datawr_d;
  logic              mem_dmwr_q, mem_dmwr_d;
  logic [2:0]        mem_dmctrl_q, mem_dmctrl_d;

  logic              win_c;
  logic              win_we_c;
  logic [2:0]        win_ctrl_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;
  logic              fault_c;

  // Winner select and payload mux; a tie goes to the port that did not win last.
  always_comb begin
    win_c       = (bus.req == 2'b11) ? ~last_grant_q : bus.req[1];
    win_we_c    = win_c ? bus.we[1] : bus.we[0];
    win_ctrl_c  = win_c ? bus.ctrl1  : bus.ctrl0;
    win_addr_c  = win_c ? bus.addr1  : bus.addr0;
    win_wdata_c = win_c ? bus.wdata1 : bus.wdata0;
  end

  dmem_fault_chk #(.MEM_BYTES(MEM_BYTES)) u_fault_chk (
    .ctrl  (win_ctrl_c),
    .addr  (win_addr_c),
    .fault (fault_c)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_grant_d  = last_grant_q;
    done_d        = 2'b00;
    rdata_d       = rdata_q;
    err_d         = err_q;
    mem_address_d = mem_address_q;
    mem_datawr_d  = mem_datawr_q;
    mem_dmwr_d    = 1'b0;
    mem_dmctrl_d  = mem_dmctrl_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          sel_d        = win_c;
          last_grant_d = win_c;
          if (fault_c) begin
            // Faulting requests skip memory and respond one cycle early.
            state_d = RESP;
            done_d  = win_c ? 2'b10 : 2'b01;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d       = ACCESS;
            mem_address_d = win_addr_c;
            mem_datawr_d  = win_wdata_c;
            mem_dmctrl_d  = win_ctrl_c;
            mem_dmwr_d    = win_we_c;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        done_d  = sel_q ? 2'b10 : 2'b01;
        err_d   = 1'b0;
        rdata_d = mem_dmwr_q ? '0 : bus.mem_datard;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      last_grant_q  <= 1'b1;
      done_q        <= 2'b00;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      mem_address_q <= '0;
      mem_datawr_q  <= '0;
      mem_dmwr_q    <= 1'b0;
      mem_dmctrl_q  <= 3'b000;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      last_grant_q  <= last_grant_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      mem_address_q <= mem_address_d;
      mem_datawr_q  <= mem_datawr_d;
      mem_dmwr_q    <= mem_dmwr_d;
      mem_dmctrl_q  <= mem_dmctrl_d;
    end
  end

  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.err         = err_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_datawr  = mem_datawr_q;
  assign bus.mem_dmwr    = mem_dmwr_q;
  assign bus.mem_dmctrl  = mem_dmctrl_q;

endmodule
